divide: RTL and testbench
=========================

# divide

Iterative radix-2 integer divider, the inverse counterpart of `multiply`. It serves the M-extension DIV/DIVU/REM/REMU path beside the multiplier and uses the same `stb`/`ack` handshake. It computes quotient and remainder of two W-bit operands, signed or unsigned, with RISC-V divide-by-zero and overflow semantics. Latency is fixed at W+1 cycles for every operand pair.

## Interface

Parameters:
- `W`, default 32: operand, quotient and remainder width, W ≥ 2.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `a`  in  W: dividend; sampled only on an accepted `stb`.
- `b`  in  W: divisor; sampled only on an accepted `stb`.
- `is_signed`  in  1: 1 means two's-complement operands and results; 0 means unsigned. Sampled with `a`/`b`.
- `q`  out  W: quotient; registered.
- `r`  out  W: remainder; registered.
- `stb`  in  1: start request.
- `ack`  out  1: one-cycle pulse; `q`/`r` are valid when it is high.

## Operation

- States: IDLE, CALC, DONE.
  - IDLE: waits for `stb`.
  - CALC: runs W iterations under a down-counter `cnt` (W-1 … 0).
  - DONE: lasts one cycle with `ack`=1.
- Accept:
  - `stb`=1 in IDLE or DONE latches the operands and moves to CALC.
  - `stb` in CALC is ignored, with no queuing and no effect on the current operation.
- Operand prep at accept (signed mode):
  - `neg_q` = sign(a) XOR sign(b).
  - `neg_r` = sign(a).
  - Divide the magnitudes |a|, |b|, held as W-bit unsigned; |−2^(W−1)| = 2^(W−1) is exact.
  - In unsigned mode both flags are 0 and the operands are used as-is.
- Iteration (restoring, one quotient bit per cycle):
  - Partial remainder `pr` is W+1 bits wide.
  - Shift `{pr, dividend}` left 1.
  - Trial = `pr` − {0,|b|}.
  - If the trial is non-negative, `pr` = trial and quotient bit = 1; otherwise `pr` is kept and the bit = 0.
- Fixup (edge leaving CALC registers `q`, `r`):
  - `b` == 0: `q` = all-ones and `r` = original `a`, in both modes and regardless of sign.
  - Otherwise:
    - `q` = `neg_q` ? −quot : quot.
    - `r` = `neg_r` ? −pr[W−1:0] : pr[W−1:0].
  - Signed overflow (a = −2^(W−1), b = −1) falls out naturally: `q` = −2^(W−1) and `r` = 0. No special case is needed; the bench checks it.
- `q`/`r` hold their value from the DONE cycle until the next completion. They do not change during CALC; the working registers are separate.
- Reset in any state:
  - Returns to IDLE.
  - `ack`=0, `q`=0, `r`=0.
  - Aborts any operation in flight; no `ack` is ever produced for it.

## Timing

- Reset values: `ack`=0, `q`=0, `r`=0, state IDLE.
- `stb` sampled high at edge E0 (state IDLE or DONE) → iterations occur on edges E1..EW.
- Edge E(W+1) registers `q`/`r`, sets `ack`=1 and enters DONE.
- `ack` is high for exactly the one cycle between E(W+1) and E(W+2).
- Latency from accept to `ack` is W+1 edges, constant; this holds for divide-by-zero and overflow too.
- Back-to-back:
  - `stb` high in the DONE cycle is accepted at E(W+2), giving one op per W+2 cycles.
  - Otherwise the block returns to IDLE at E(W+2).
- `rst` and `stb` asserted in the same cycle: reset wins and the request is dropped.
- All datapath is in one cycle per iteration; no multicycle paths.

## Test plan

- Unsigned, W=32:
  - a=100, b=7, `stb` at E0 → `ack` only in the cycle after E33, `q`=14, `r`=2.
  - `ack` is never high otherwise.
- Signed sign rules:
  - −7/2 → `q`=0xFFFFFFFD, `r`=0xFFFFFFFF.
  - 7/−2 → `q`=0xFFFFFFFD, `r`=1.
  - −7/−2 → `q`=3, `r`=0xFFFFFFFF.
- Divide by zero:
  - Signed a=0xFFFFFFF9, b=0 → `q`=0xFFFFFFFF, `r`=0xFFFFFFF9.
  - Unsigned a=5, b=0 → `q`=0xFFFFFFFF, `r`=5.
  - Latency is still 33 in both cases.
- Overflow / mode contrast with a=0x80000000, b=0xFFFFFFFF:
  - Signed → `q`=0x80000000, `r`=0.
  - Unsigned → `q`=0, `r`=0x80000000.
- Handshake:
  - Pulse `stb` with new operands at E5 during CALC → ignored; the first result is unchanged and there is only one `ack`.
  - `stb` during the DONE cycle → second `ack` exactly 34 edges after the first, with correct second result.
  - `q`/`r` stay stable through the second CALC.
- Reset mid-operation:
  - Assert `rst` at E10 of an operation → `ack`=0, `q`=0, `r`=0, IDLE next cycle.
  - No late `ack` appears.
  - A fresh `stb` afterwards completes normally in 33 edges.

Source files
------------

// File: rtl/divide.sv
// Iterative radix-2 restoring divider, signed/unsigned, RISC-V div-by-zero and overflow results.
// Latency: W+1 edges from accepted stb to the one-cycle ack pulse, for every operand pair.
// Backpressure: none; stb is accepted in IDLE or DONE and ignored while CALC is busy.
module divide #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    input  logic         stb,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         ack
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fix_q, fix_d;
    logic [W:0]    pr_q, pr_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  a_orig_q, a_orig_d;
    logic          bz_q, bz_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  r_q, r_d;
    logic          ack_q, ack_d;

    logic          a_neg, b_neg;
    logic [W-1:0]  a_mag, b_mag;
    logic [W+1:0]  shifted, trial;
    logic          take_bit;
    logic [W-1:0]  rem;

    always_comb begin
        a_neg    = is_signed & a[W-1];
        b_neg    = is_signed & b[W-1];
        // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
        a_mag    = a_neg ? (~a + W'(1)) : a;
        b_mag    = b_neg ? (~b + W'(1)) : b;

        shifted  = {pr_q, dvd_q[W-1]};
        trial    = shifted - {2'b00, dvs_q};
        take_bit = ~trial[W+1];
        rem      = pr_q[W-1:0];

        state_d   = state_q;
        cnt_d     = cnt_q;
        fix_d     = fix_q;
        pr_d      = pr_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        a_orig_d  = a_orig_q;
        bz_d      = bz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        q_d       = q_q;
        r_d       = r_q;
        ack_d     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (stb) begin
                    state_d   = CALC;
                    cnt_d     = CNT_INIT;
                    fix_d     = 1'b0;
                    pr_d      = '0;
                    dvd_d     = a_mag;
                    dvs_d     = b_mag;
                    a_orig_d  = a;
                    bz_d      = (b == '0);
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (fix_q) begin
                    // dvd_q now holds the unsigned quotient, pr_q the unsigned remainder.
                    if (bz_q) begin
                        q_d = '1;
                        r_d = a_orig_q;
                    end else begin
                        q_d = neg_quo_q ? (~dvd_q + W'(1)) : dvd_q;
                        r_d = neg_rem_q ? (~rem + W'(1)) : rem;
                    end
                    fix_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    pr_d  = take_bit ? trial[W:0] : shifted[W:0];
                    dvd_d = {dvd_q[W-2:0], take_bit};
                    if (cnt_q == '0) begin
                        fix_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fix_q     <= 1'b0;
            pr_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            a_orig_q  <= '0;
            bz_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fix_q     <= fix_d;
            pr_q      <= pr_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            a_orig_q  <= a_orig_d;
            bz_q      <= bz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            q_q       <= q_d;
            r_q       <= r_d;
            ack_q     <= ack_d;
        end
    end

    assign q   = q_q;
    assign r   = r_q;
    assign ack = ack_q;

endmodule

// File: tb/tb_divide.sv
// Bench for divide (W=32): directed vector table, handshake/reset sequences, random ops vs arithmetic model.
module tb_divide;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk;
    logic          rst;
    logic [W-1:0]  a, b;
    logic          is_signed;
    logic          stb;
    logic [W-1:0]  q, r;
    logic          ack;

    int n_cmp = 0;
    int n_err = 0;

    divide #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .stb       (stb),
        .q         (q),
        .r         (r),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    // Reference: RISC-V semantics straight from plain integer arithmetic.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                                  output logic [31:0] eq, output logic [31:0] er);
        longint sa, sb;
        if (mb == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = ma;
        end else if (ms) begin
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
            eq = 32'(sa / sb);
            er = 32'(sa % sb);
        end else begin
            eq = ma / mb;
            er = ma % mb;
        end
    endfunction

    // Called just after a rising edge; returns just after the accepting edge E0.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
        a = ta; b = tb_; is_signed = ts; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    endtask

    task automatic wait_done(input int exp_lat, input string nm);
        int lat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 100);
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic count_acks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
    endtask

    vec_t        vt[10];
    logic [31:0] e1q, e1r, e2q, e2r, ra, rb;
    logic        rs;
    int          nack, n;
    logic        stable;

    initial begin
        rst = 1'b1; a = '0; b = '0; is_signed = 1'b0; stb = 1'b0;

        vt[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vt[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vt[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vt[3] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF};
        vt[4] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9};
        vt[5] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
        vt[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vt[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
        vt[8] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vt[9] = '{32'd7,          32'd7,          1'b1, 32'd1,          32'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_q", q, 32'd0);
        chk("reset_r", r, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        foreach (vt[i]) begin
            start_op(vt[i].a, vt[i].b, vt[i].s);
            wait_done(LAT, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_q", i), q, vt[i].eq);
            chk($sformatf("vec%0d_r", i), r, vt[i].er);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ack_pulse", i), {31'd0, ack}, 32'd0);
        end

        // stb during CALC is ignored
        model(32'd1000, 32'd9, 1'b0, e1q, e1r);
        start_op(32'd1000, 32'd9, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        a = 32'd77; b = 32'd3; is_signed = 1'b0; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        wait_done(LAT - 5, "busy_stb");
        chk("busy_stb_q", q, e1q);
        chk("busy_stb_r", r, e1r);
        count_acks(40, nack);
        chk("busy_stb_extra_acks", 32'(nack), 32'd0);

        // Back-to-back: stb in the DONE cycle
        model(32'hFFFF_FF00, 32'd3, 1'b1, e1q, e1r);
        model(32'd12345, 32'd100, 1'b0, e2q, e2r);
        start_op(32'hFFFF_FF00, 32'd3, 1'b1);
        wait_done(LAT, "b2b_first");
        chk("b2b_first_q", q, e1q);
        chk("b2b_first_r", r, e1r);
        start_op(32'd12345, 32'd100, 1'b0);
        stable = 1'b1;
        n = 1;
        while (!ack && n < 100) begin
            if (q !== e1q || r !== e1r) stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_ack_spacing", 32'(n), 32'(W + 2));
        chk("b2b_hold_stable", {31'd0, stable}, 32'd1);
        chk("b2b_second_q", q, e2q);
        chk("b2b_second_r", r, e2r);

        // Reset mid-operation at E10
        start_op(32'd999, 32'd10, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_q", q, 32'd0);
        chk("midrst_r", r, 32'd0);
        count_acks(40, nack);
        chk("midrst_late_ack", 32'(nack), 32'd0);
        model(32'hFFFF_FFF0, 32'd5, 1'b1, e1q, e1r);
        start_op(32'hFFFF_FFF0, 32'd5, 1'b1);
        wait_done(LAT, "after_rst");
        chk("after_rst_q", q, e1q);
        chk("after_rst_r", r, e1r);
        @(posedge clk); #1;

        // rst and stb together: request dropped
        a = 32'd50; b = 32'd5; is_signed = 1'b0; stb = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0; rst = 1'b0;
        count_acks(40, nack);
        chk("rst_stb_dropped", 32'(nack), 32'd0);

        // Random ops against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            rs = 1'($urandom);
            model(ra, rb, rs, e1q, e1r);
            start_op(ra, rb, rs);
            wait_done(LAT, $sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_q a=%h b=%h s=%0d", i, ra, rb, rs), q, e1q);
            chk($sformatf("rnd%0d_r a=%h b=%h s=%0d", i, ra, rb, rs), r, e1r);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
